serial_pattern_gen: RTL
=======================

Name: serial_pattern_gen

Overview:
Serial bit-sequence transmitter: the driving end of the single-bit serial stream consumed by the sequence detectors.
- Latches a pattern of up to PAT_W bits and shifts it out MSB-first on one output line.
- Each bit is held for a fixed number of clocks.
- Supports a repetition count and a programmable idle gap between repetitions.
- Used both as on-board stimulus for detector self-test and as the bench stimulus source in place of hand-written delay chains.

Parameters:
PAT_W, 12, maximum pattern length in bits
LEN_W, 4, width of pat_len; must satisfy 2^LEN_W > PAT_W
CNT_W, 4, width of rep_count and rep_idx
GAP_W, 4, width of gap_len
DIV, 1, clocks each bit is held on x (>=1)
IDLE_LVL, 1'b0, level of x whenever no bit is being driven

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin transmission; sampled only in IDLE
abort  input  1  stop transmission and return to IDLE
pattern  input  PAT_W  bits to send, bit pat_len-1 first; latched on accepted start
pat_len  input  LEN_W  number of bits to send; latched on accepted start
rep_count  input  CNT_W  repetitions; 0 = repeat until abort; latched on accepted start
gap_len  input  GAP_W  idle clocks between repetitions; latched on accepted start
x  output  1  serial data out, registered
x_valid  output  1  high while x carries a pattern bit
busy  output  1  high from accepted start until completion or abort
done  output  1  one-cycle pulse on normal completion
rep_idx  output  CNT_W  index of the current repetition, 0-based

Behaviour:
- All outputs are registered. On reset (asynchronous, any time, including mid-transmission): x=IDLE_LVL, x_valid=0, busy=0, done=0, rep_idx=0, FSM=IDLE, internal counters cleared.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 and abort=0 at an edge: latch pattern, effective length L, rep_count, gap_len. Go to SHIFT.
  - In the next cycle: x=pattern[L-1], x_valid=1, busy=1, rep_idx=0. First bit appears 1 clock after start.
- Effective length L: pat_len=0 or pat_len>PAT_W gives L=PAT_W; otherwise L=pat_len.
- SHIFT:
  - Each bit is held DIV clocks. Bit index decrements from L-1 to 0.
  - After bit 0 has been held DIV clocks, the repetition is complete:
    - Last repetition (rep_count!=0 and rep_idx==rep_count-1): go to IDLE. In that next cycle, done=1 for one cycle, busy=0, x_valid=0, x=IDLE_LVL.
    - Otherwise, gap_len>0: go to GAP. x=IDLE_LVL and x_valid=0 for exactly gap_len cycles. rep_idx increments on entry to GAP.
    - Otherwise, gap_len=0: the next repetition's first bit follows bit 0 back-to-back with no idle cycle. rep_idx increments in that same cycle.
- GAP: after gap_len cycles, return to SHIFT with bit index L-1. Bits follow the same timing as the first repetition.
- rep_count=0: transmission continues indefinitely. rep_idx wraps modulo 2^CNT_W. done is never asserted.
- abort=1 in SHIFT or GAP:
  - Next cycle: IDLE, x=IDLE_LVL, x_valid=0, busy=0, rep_idx=0.
  - done stays 0.
  - The bit in flight is truncated.
- Simultaneous events:
  - start and abort together in IDLE: abort wins, remain IDLE.
  - start while busy: ignored, latched values unchanged.
  - start in the same cycle that done pulses: accepted. FSM is IDLE in that cycle, so the next transmission begins on the following cycle.
- Input changes to pattern, pat_len, rep_count and gap_len while busy have no effect.

Test Plan:
1. DIV=1, pattern=12'b001101100110, pat_len=12, rep_count=1, gap_len=0, start pulse at cycle 0 -> x over cycles 1..12 = 0,0,1,1,0,1,1,0,0,1,1,0 with x_valid=1; cycle 13: done=1, busy=0, x=0.
2. pattern=12'b000000001011, pat_len=4, rep_count=2, gap_len=3 -> x = 1,0,1,1, then 3 cycles x=0/x_valid=0, then 1,0,1,1; rep_idx 0 then 1; single done pulse after the 2nd repetition.
3. pat_len=0 and pat_len=15 with pattern=12'hA5C -> both send all 12 bits, 1010_0101_1100; pat_len=3, rep_count=2, gap_len=0 with the same pattern -> 1,0,0,1,0,0 back-to-back, rep_idx 0->1 exactly at the 4th bit.
4. rep_count=0, pat_len=2, pattern=2'b10, gap_len=1; abort asserted during the 7th repetition, mid-bit -> continuous 1,0,gap pattern; cycle after abort: busy=0, x_valid=0, x=IDLE_LVL, rep_idx=0, done never high.
5. Reset asserted asynchronously (between clock edges) mid-SHIFT -> outputs reach reset values immediately without a clock edge; after release, a new start transmits normally from bit L-1.
6. Handshake corners: start while busy changes nothing; start+abort in IDLE stays IDLE; start in the done cycle begins a new transmission one cycle later; DIV=3 holds each bit exactly 3 clocks.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Serial bit-sequence transmitter: shifts a latched pattern out MSB-first on x,
// holding each bit DIV clocks, with a repetition count and an idle gap between repetitions.
module serial_pattern_gen #(
    parameter int   PAT_W    = 12,
    parameter int   LEN_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP_W    = 4,
    parameter int   DIV      = 1,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rep_idx
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r, len_in, bit_idx, bit_idx_n;
    logic [CNT_W-1:0] rep_r, rep_idx_n;
    logic [GAP_W-1:0] gap_r, gap_cnt, gap_cnt_n;
    logic [DW-1:0]    div_cnt, div_cnt_n;
    logic             x_n, x_valid_n, busy_n, done_n, load;
    logic             bit_end, last_rep;

    // Zero or out-of-range lengths fall back to the full pattern width
    assign len_in   = (pat_len == '0 || pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    assign bit_end  = (div_cnt == DW'(DIV - 1));
    assign last_rep = (rep_r != '0) && (rep_idx == rep_r - CNT_W'(1));

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        div_cnt_n = div_cnt;
        gap_cnt_n = gap_cnt;
        rep_idx_n = rep_idx;
        x_n       = x;
        x_valid_n = x_valid;
        busy_n    = busy;
        done_n    = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load      = 1'b1;
                    state_n   = SHIFT;
                    bit_idx_n = len_in - LEN_W'(1);
                    div_cnt_n = '0;
                    rep_idx_n = '0;
                    x_n       = pattern[len_in - LEN_W'(1)];
                    x_valid_n = 1'b1;
                    busy_n    = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n   = IDLE;
                    x_n       = IDLE_LVL;
                    x_valid_n = 1'b0;
                    busy_n    = 1'b0;
                    rep_idx_n = '0;
                end else if (!bit_end) begin
                    div_cnt_n = div_cnt + DW'(1);
                end else begin
                    div_cnt_n = '0;
                    if (bit_idx != '0) begin
                        bit_idx_n = bit_idx - LEN_W'(1);
                        x_n       = pat_r[bit_idx - LEN_W'(1)];
                    end else if (last_rep) begin
                        state_n   = IDLE;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        x_valid_n = 1'b0;
                        x_n       = IDLE_LVL;
                    end else begin
                        rep_idx_n = rep_idx + CNT_W'(1);
                        if (gap_r != '0) begin
                            state_n   = GAP;
                            gap_cnt_n = '0;
                            x_n       = IDLE_LVL;
                            x_valid_n = 1'b0;
                        end else begin
                            bit_idx_n = len_r - LEN_W'(1);
                            x_n       = pat_r[len_r - LEN_W'(1)];
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_n   = IDLE;
                    x_n       = IDLE_LVL;
                    x_valid_n = 1'b0;
                    busy_n    = 1'b0;
                    rep_idx_n = '0;
                end else if (gap_cnt == gap_r - GAP_W'(1)) begin
                    state_n   = SHIFT;
                    bit_idx_n = len_r - LEN_W'(1);
                    div_cnt_n = '0;
                    x_n       = pat_r[len_r - LEN_W'(1)];
                    x_valid_n = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pat_r   <= '0;
            len_r   <= '0;
            rep_r   <= '0;
            gap_r   <= '0;
            bit_idx <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            rep_idx <= '0;
            x       <= IDLE_LVL;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            div_cnt <= div_cnt_n;
            gap_cnt <= gap_cnt_n;
            rep_idx <= rep_idx_n;
            x       <= x_n;
            x_valid <= x_valid_n;
            busy    <= busy_n;
            done    <= done_n;
            if (load) begin
                pat_r <= pattern;
                len_r <= len_in;
                rep_r <= rep_count;
                gap_r <= gap_len;
            end
        end
    end

endmodule
